// File: rtl/lfsr_arbiter.sv
// Shared 13-bit LFSR noise source (taps 12,3,2,0). Each fully refreshed word
// goes to exactly one requester, picked round-robin.
module lfsr_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int          SHIFTS  = 13,
  parameter logic [12:0] SEED    = 13'h000F
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       seed_load,
  input  logic [12:0]                seed_value,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [12:0]                rnd,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SHIFTS + 1);

  logic [12:0]      lfsr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [IW-1:0]    ptr_reg;

  logic             fb;
  logic [12:0]      lfsr_next;
  logic [IW-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    ptr_next;
  logic [NUM_REQ-1:0] win_onehot;
  logic             ready;
  logic             grant;

  assign fb        = lfsr_reg[12] ^ lfsr_reg[3] ^ lfsr_reg[2] ^ lfsr_reg[0];
  // An all-zero register would never leave zero; reload the seed instead.
  assign lfsr_next = (lfsr_reg == 13'd0) ? SEED : {lfsr_reg[11:0], fb};

  // Candidate gi is the client gi places after the round-robin pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum           = {1'b0, ptr_reg} + (IW+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                                     : sum[IW-1:0];
    assign cand_req[gi]  = req[cand_idx[gi]];
    assign win_onehot[gi] = (win_idx == IW'(gi));
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign ready    = (cnt_reg == CW'(SHIFTS));
  assign grant    = ready && win_found;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED;
      cnt_reg  <= '0;
      ptr_reg  <= '0;
      ack      <= '0;
      rnd      <= '0;
      grant_id <= '0;
    end else begin
      ack <= '0;
      if (seed_load) begin
        lfsr_reg <= (seed_value == 13'd0) ? SEED : seed_value;
        cnt_reg  <= '0;
      end else begin
        if (grant) begin
          ack      <= win_onehot;
          rnd      <= lfsr_reg;
          grant_id <= win_idx;
          ptr_reg  <= ptr_next;
        end
        if (enable) begin
          lfsr_reg <= lfsr_next;
        end
        if (grant) begin
          cnt_reg <= '0;
        end else if (enable && !ready) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule
